zpu_bram_loader: RTL and testbench

//  Byte-stream program loader upstream of the ZPU dual-port BRAM. Frames

---
 rtl/zpu_bram_loader.sv | 132 +++++++++++++
 tb/tb_zpu_bram_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/zpu_bram_loader.sv
// zpu_bram_loader: byte-stream frame loader into ZPU BRAM port B; LOADER_VERIFY_EN adds write readback check
module zpu_bram_loader #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W = 15,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 memBWriteEnable,
    output logic [ADDR_W-1:0]    memBAddr,
    output logic [WORD_SIZE-1:0] memBWrite,
    input  logic [WORD_SIZE-1:0] memBRead,
    output logic                 zpu_hold,
    output logic                 done,
    output logic [1:0]           err
);
    typedef enum logic [3:0] {IDLE, LEN_H, LEN_L, DATA, WRITE, RD, CMP, CSUM, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] csum_q, csum_d;
    logic [1:0] err_q, err_d;
    logic hold_q, hold_d, rdy_q, rdy_d, we_q, we_d, done_q, done_d, acc, adv;
    assign acc = in_valid & rdy_q;
`ifdef LOADER_VERIFY_EN
    assign adv = state_q == CMP;
`else
    logic unused_rd;
    assign unused_rd = ^memBRead;
    assign adv = state_q == WRITE;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        bcnt_d = bcnt_q;
        word_d = word_q;
        addr_d = addr_q;
        csum_d = csum_q;
        err_d = err_q;
        hold_d = hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    hold_d = 1'b0;
                    state_d = IDLE;
                end
                // a header arriving in DONE starts the next frame without loss
                if (acc && in_data == HDR_BYTE) begin
                    state_d = LEN_H;
                    err_d = 2'b00;
                    csum_d = 8'd0;
                    addr_d = '0;
                    hold_d = 1'b1;
                end
            end
            LEN_H: if (acc) begin
                cnt_d[15:8] = in_data;
                csum_d = csum_q + in_data;
                state_d = LEN_L;
            end
            LEN_L: if (acc) begin
                cnt_d[7:0] = in_data;
                csum_d = csum_q + in_data;
                bcnt_d = 2'd0;
                state_d = {cnt_q[15:8], in_data} == 16'd0 ? CSUM : DATA;
            end
            DATA: if (acc) begin
                word_d = {word_q[WORD_SIZE-9:0], in_data};
                csum_d = csum_q + in_data;
                bcnt_d = bcnt_q + 2'd1;
                state_d = bcnt_q == 2'd3 ? WRITE : DATA;
            end
`ifdef LOADER_VERIFY_EN
            WRITE: state_d = RD;
            RD: state_d = CMP;
            CMP: if (memBRead != word_q) err_d[1] = 1'b1;
`endif
            CSUM: if (acc) begin
                if (in_data != csum_q) err_d[0] = 1'b1;
                state_d = DONE;
            end
            default: state_d = state_q;
        endcase
        if (adv) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d = cnt_q - 16'd1;
            state_d = cnt_q == 16'd1 ? CSUM : DATA;
        end
        rdy_d = !(state_d inside {WRITE, RD, CMP});
        we_d = state_d == WRITE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= 16'd0;
            bcnt_q <= 2'd0;
            word_q <= '0;
            addr_q <= '0;
            csum_q <= 8'd0;
            err_q <= 2'b00;
            hold_q <= 1'b0;
            rdy_q <= 1'b1;
            we_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bcnt_q <= bcnt_d;
            word_q <= word_d;
            addr_q <= addr_d;
            csum_q <= csum_d;
            err_q <= err_d;
            hold_q <= hold_d;
            rdy_q <= rdy_d;
            we_q <= we_d;
            done_q <= done_d;
        end
    end
    assign in_ready = rdy_q;
    assign memBWriteEnable = we_q;
    assign memBAddr = addr_q;
    assign memBWrite = word_q;
    assign zpu_hold = hold_q;
    assign done = done_q;
    assign err = err_q;
endmodule

// File: tb/tb_zpu_bram_loader.sv
// tb_zpu_bram_loader: directed frames, expected writes/done events queued and checked by a monitor
module tb_zpu_bram_loader;
`ifdef LOADER_VERIFY_EN
    localparam int BUSY = 3;
`else
    localparam int BUSY = 1;
`endif
    logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_ready;
    logic [7:0] in_data = 8'd0;
    logic memBWriteEnable, zpu_hold, done;
    logic [14:0] memBAddr;
    logic [31:0] memBWrite, memBRead;
    logic [1:0] err;
    logic [31:0] mem [0:32767];
    logic [46:0] exp_wr[$];
    logic [1:0] exp_done[$];
    int n_cmp = 0, n_bad = 0, busy_cnt = 0;
    bit cnt_en = 0, rd_zero = 0;

    zpu_bram_loader dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .memBWriteEnable(memBWriteEnable), .memBAddr(memBAddr),
        .memBWrite(memBWrite), .memBRead(memBRead), .zpu_hold(zpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memBWriteEnable) mem[memBAddr] <= memBWrite;
        memBRead <= rd_zero ? 32'd0 : mem[memBAddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        if (cnt_en && !in_ready) busy_cnt++;
        if (memBWriteEnable && done) check("we_done_overlap", 64'd1, 64'd0);
        if (memBWriteEnable) begin
            if (exp_wr.size() == 0) check("unexpected_write", {17'd0, memBAddr, memBWrite}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("write", {17'd0, memBAddr, memBWrite}, {17'd0, exp_wr.pop_front()});
        end
        if (done) begin
            if (exp_done.size() == 0) check("unexpected_done", {62'd0, err}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("done_err", {62'd0, err}, {62'd0, exp_done.pop_front()});
        end
    end

    task automatic send(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, {32'd0, exp_wr.size(), exp_done.size()}, 64'd0);
        exp_wr.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check(name, {11'd0, in_ready, memBWriteEnable, memBAddr, memBWrite, zpu_hold, done, err},
              {11'd0, 1'b1, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0, 2'b00});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        reset_n = 1'b1;
        // good single-word frame
        exp_wr.push_back({15'd0, 32'hDEADBEEF});
        exp_done.push_back(2'b00);
        send(8'hA5);
        send(8'h00);
        check("hold_in_frame", {63'd0, zpu_hold}, 64'd1);
        send_bytes('{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39});
        drain("t1_drain");
        // bad checksum: word still written
        exp_wr.push_back({15'd0, 32'hDEADBEEF});
        exp_done.push_back(2'b01);
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38});
        drain("t2_drain");
        check("hold_after_bad", {63'd0, zpu_hold}, 64'd0);
        check("err_sticky", {62'd0, err}, 64'd1);
        // garbage then empty frame
        exp_done.push_back(2'b00);
        send_bytes('{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00});
        drain("t3_drain");
        // reset mid-frame
        send_bytes('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22});
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_frame");
        @(negedge clk);
        reset_n = 1'b1;
        exp_wr.push_back({15'd0, 32'h12345678});
        exp_done.push_back(2'b00);
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15});
        drain("t4_drain");
        // continuous valid, three words
        exp_wr.push_back({15'd0, 32'h01020304});
        exp_wr.push_back({15'd1, 32'h05060708});
        exp_wr.push_back({15'd2, 32'h090A0B0C});
        exp_done.push_back(2'b00);
        busy_cnt = 0;
        cnt_en = 1;
        send_bytes('{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                     8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h51});
        drain("t5_drain");
        cnt_en = 0;
        check("busy_cycles", 64'(busy_cnt), 64'(3 * BUSY));
`ifdef LOADER_VERIFY_EN
        rd_zero = 1;
        exp_wr.push_back({15'd0, 32'hDEADBEEF});
        exp_done.push_back(2'b10);
        send_bytes('{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39});
        drain("t6_drain");
        rd_zero = 0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
